// File: rtl/mips_instr_encoder_if.sv
// Request/stream bundle for mips_instr_encoder.
// slave = encoder view, master = producer/consumer view.
interface mips_instr_encoder_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            in_kind;
    logic [4:0]            in_rs;
    logic [4:0]            in_rt;
    logic [4:0]            in_rd;
    logic [15:0]           in_imm;
    logic [25:0]           in_target;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_instr;
    logic [ADDR_WIDTH-1:0] out_addr;

    modport slave (
        input  in_valid, in_kind, in_rs, in_rt,
        input  in_rd, in_imm, in_target, out_ready,
        output in_ready, out_valid, out_instr, out_addr
    );

    modport master (
        output in_valid, in_kind, in_rs, in_rt,
        output in_rd, in_imm, in_target, out_ready,
        input  in_ready, out_valid, out_instr, out_addr
    );
endinterface

// File: rtl/mips_instr_encoder.sv
// Mnemonic-level MIPS encoder with address-tagged output FIFO.
// Define ENC_DELAY_SLOT_NOP_EN to pad each BEQ/J with a NOP.
module mips_instr_encoder #(
    parameter int                   ADDR_WIDTH = 8,
    parameter int                   FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    mips_instr_encoder_if.slave      bus,
    output logic [15:0]              word_count,
    output logic                     err_illegal
);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [31:0]           r_mem  [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_amem [FIFO_DEPTH];
    logic [PW:0]           r_wr;
    logic [PW:0]           r_rd;
    logic [ADDR_WIDTH-1:0] r_next_addr;
    logic [15:0]           r_count;
    logic                  r_err;
    logic [31:0]           r_hold_instr;
    logic [ADDR_WIDTH-1:0] r_hold_addr;

    logic        w_full;
    logic        w_empty;
    logic        w_accept;
    logic        w_legal;
    logic [31:0] w_enc;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_wdata;
    logic        w_nop_pending;
    logic        w_nop_push;
    logic [PW-1:0] w_wr_idx;
    logic [PW-1:0] w_rd_idx;

    assign w_wr_idx = r_wr[PW-1:0];
    assign w_rd_idx = r_rd[PW-1:0];
    assign w_empty  = (r_wr == r_rd);
    assign w_full   = (r_wr[PW] != r_rd[PW]) &&
                      (w_wr_idx == w_rd_idx);

    assign bus.in_ready = !reset && !w_full && !w_nop_pending;
    assign w_accept     = bus.in_valid && bus.in_ready;

    always_comb begin
        w_enc   = '0;
        w_legal = 1'b1;
        case (bus.in_kind)
            4'd0: w_enc = {6'h00, bus.in_rs, bus.in_rt,
                           bus.in_rd, 5'h00, 6'h20};
            4'd1: w_enc = {6'h00, bus.in_rs, bus.in_rt,
                           bus.in_rd, 5'h00, 6'h22};
            4'd2: w_enc = {6'h00, bus.in_rs, bus.in_rt,
                           bus.in_rd, 5'h00, 6'h24};
            4'd3: w_enc = {6'h00, bus.in_rs, bus.in_rt,
                           bus.in_rd, 5'h00, 6'h25};
            4'd4: w_enc = {6'h00, bus.in_rs, bus.in_rt,
                           bus.in_rd, 5'h00, 6'h2A};
            4'd5: w_enc = {6'h23, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd6: w_enc = {6'h2B, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd7: w_enc = {6'h04, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd8: w_enc = {6'h02, bus.in_target};
            4'd9: w_enc = {6'h08, bus.in_rs, bus.in_rt, bus.in_imm};
            default: w_legal = 1'b0;
        endcase
    end

`ifdef ENC_DELAY_SLOT_NOP_EN
    logic r_nop_pending;
    logic w_branch;

    assign w_branch      = (bus.in_kind == 4'd7) ||
                           (bus.in_kind == 4'd8);
    assign w_nop_pending = r_nop_pending;
    // in_ready is low while pending, so a NOP never collides with a request
    assign w_nop_push    = r_nop_pending && !w_full;

    always_ff @(posedge clk) begin
        if (reset)
            r_nop_pending <= 1'b0;
        else if (w_nop_push)
            r_nop_pending <= 1'b0;
        else if (w_accept && w_branch)
            r_nop_pending <= 1'b1;
    end
`else
    assign w_nop_pending = 1'b0;
    assign w_nop_push    = 1'b0;
`endif

    assign w_push  = (w_accept && w_legal) || w_nop_push;
    assign w_wdata = w_nop_push ? 32'h0 : w_enc;
    assign w_pop   = !w_empty && bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr         <= '0;
            r_rd         <= '0;
            r_next_addr  <= BASE_ADDR;
            r_count      <= '0;
            r_err        <= 1'b0;
            r_hold_instr <= '0;
            r_hold_addr  <= BASE_ADDR;
        end else begin
            if (w_push) begin
                r_wr        <= r_wr + (PW+1)'(1);
                r_next_addr <= r_next_addr + ADDR_WIDTH'(4);
                if (r_count != 16'hFFFF)
                    r_count <= r_count + 16'd1;
            end
            if (w_pop) begin
                r_rd         <= r_rd + (PW+1)'(1);
                r_hold_instr <= r_mem[w_rd_idx];
                r_hold_addr  <= r_amem[w_rd_idx];
            end
            if (w_accept && !w_legal)
                r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_wr_idx]  <= w_wdata;
            r_amem[w_wr_idx] <= r_next_addr;
        end
    end

    // Empty FIFO shows the last word popped (or reset values)
    assign bus.out_valid = !w_empty;
    assign bus.out_instr = w_empty ? r_hold_instr : r_mem[w_rd_idx];
    assign bus.out_addr  = w_empty ? r_hold_addr  : r_amem[w_rd_idx];
    assign word_count    = r_count;
    assign err_illegal   = r_err;
endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
Encoder counterpart to the single-cycle control decoder. It accepts instruction requests at the mnemonic level and packs each one into a 32-bit MIPS word using the same opcode and funct encodings the decoder consumes. Encoded words are tagged with a sequential byte address and buffered in a small FIFO. A valid/ready stream drains the FIFO into the instruction-memory loader, so programs can be generated in hardware.

Parameters:
ADDR_WIDTH, 8, width of out_addr (byte address); wraps modulo 2^ADDR_WIDTH.
FIFO_DEPTH, 4, number of output FIFO entries; power of two, ≥2.
BASE_ADDR, 0, byte address assigned to the first word after reset; multiple of 4.

Ports:
clk  input  1  single clock; all logic updates on the rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  request present.
in_ready  output  1  encoder can accept the request this cycle.
in_kind  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8 J, 9 ADDI; 10–15 illegal.
in_rs  input  5  source register rs.
in_rt  input  5  register rt.
in_rd  input  5  destination register rd (R-type only).
in_imm  input  16  immediate or offset (I-type only).
in_target  input  26  jump target field (J only).
out_valid  output  1  FIFO head valid.
out_ready  input  1  consumer accepts the head word.
out_instr  output  32  encoded instruction at the FIFO head.
out_addr  output  ADDR_WIDTH  byte address of the head word.
word_count  output  16  words enqueued since reset; saturates at 0xFFFF.
err_illegal  output  1  sticky flag: an illegal in_kind was accepted.

Behaviour:
- Reset, synchronous (takes effect even mid-stream):
  - FIFO emptied; out_valid=0, out_instr=0, out_addr=BASE_ADDR.
  - Next-address counter set to BASE_ADDR; word_count=0; err_illegal=0; pending-NOP flag cleared.
  - in_ready=0 during the reset cycle.
- Request handshake:
  - A request is accepted on a rising edge with in_valid & in_ready.
  - in_ready = !reset & !fifo_full & !nop_pending. It is computed from the registered state only, so a pop in the same cycle does not free a slot for a push when the FIFO is full.
- Encoding (combinational, written into the FIFO on acceptance, so latency to out_valid is 1 cycle):
  - R-type: {6'h00, rs, rt, rd, 5'h00, funct}; funct ADD=0x20, SUB=0x22, AND=0x24, OR=0x25, SLT=0x2A.
  - I-type: {op, rs, rt, imm}; op LW=0x23, SW=0x2B, BEQ=0x04, ADDI=0x08.
  - J: {6'h02, target}.
  - Fields not used by a format are ignored.
- Illegal kind: the request is accepted (consumed) but nothing is enqueued. err_illegal sets the next cycle and holds until reset. Address and word_count do not change.
- Addressing:
  - Each enqueued word takes the current next-address value, which then increments by 4.
  - The counter wraps from 2^ADDR_WIDTH−4 to 0 with no flag.
  - out_addr always shows the address stored with the head entry.
- FIFO:
  - A pop occurs on out_valid & out_ready. Push and pop in the same cycle are legal when not full.
  - Head data must stay stable while out_valid=1 and out_ready=0.
  - When empty, out_valid=0; out_instr and out_addr hold their last values.
- word_count increments once per enqueued word, including padding NOPs when the optional feature is enabled.

Optional Feature:
Macro ENC_DELAY_SLOT_NOP_EN.
- Defined:
  - Accepting a BEQ or J sets nop_pending, which drops in_ready.
  - On the next cycle in which the FIFO is not full, the encoder enqueues 0x00000000 at the next address and clears nop_pending.
  - The branch and its NOP are always at consecutive addresses.
  - Reset clears nop_pending.
- Undefined: no padding; nop_pending is tied to 0.

Test Plan:
- Basic encode: after reset, ADD rs=1 rt=2 rd=3, out_ready=1 → out_instr=0x00221820 and out_addr=0x00 one cycle later; word_count=1.
- Mixed sequence: LW rs=29 rt=8 imm=0x0004, then ADDI rs=0 rt=1 imm=5, then J target=0x0000010 → words 0x8FA80004, 0x20010005, 0x08000010 at addresses 0x00, 0x04, 0x08.
- Backpressure: out_ready=0, issue 5 back-to-back requests → 4 accepted, in_ready=0 on the 5th. Head stable at the first word. Raise out_ready → all 4 drain in order, then the 5th is accepted.
- Illegal kind: in_kind=12 → accepted, nothing enqueued, err_illegal=1 from the next cycle, word_count unchanged. A following SW rs=2 rt=3 imm=0x0010 → 0xAC430010 at the unchanged address.
- Wrap and reset: ADDR_WIDTH=8, issue 65 words → the 65th is at address 0x00. Assert reset with 3 words buffered → out_valid=0, next word goes to BASE_ADDR, err_illegal=0.
- Feature on: BEQ rs=1 rt=2 imm=0xFFFF → 0x1022FFFF at 0x00, then 0x00000000 at 0x04. in_ready=0 for exactly the padding cycle; word_count=2.
